// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Register map (word addresses, full-width compare):
//   0 TXDATA  write pushes data_in[7:0]; reads return 0
//   1 STATUS  {.., count[4+FIFO_AW:4], overflow, busy, empty, full};
//             any write clears the sticky overflow bit
//   other     reads return 0, writes ignored
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   write_enable  bus write strobe (one cycle per write)
//   read_enable   bus read strobe; data_out loads on the edge, else holds
//   address       word address within the peripheral
//   data_in       write data (only [7:0] used)
//   data_out      registered read data
//   uart_tx       serial line, idle high, driven straight from a flop
module uart_tx_mmio #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_AW      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  uart_tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(DELAY_FRAMES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;

  state_t             state, state_d;
  logic [CW-1:0]      bit_cnt, bit_cnt_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shift, shift_d;
  logic               tx_d;

  logic               sel_tx, sel_st;
  logic               full, empty, busy;
  logic               wr_tx, push, pop, bit_done;
  logic [31:0]        status, rdata;

  // Upper write-data bits have no function in this peripheral.
  logic               unused_data;
  assign unused_data = ^data_in[31:8];

  assign sel_tx   = (address == ADDR_WIDTH'(0));
  assign sel_st   = (address == ADDR_WIDTH'(1));
  assign full     = (count == (FIFO_AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign wr_tx    = write_enable && sel_tx;
  // Fullness is judged on the pre-edge count, so a pop on the same edge
  // does not rescue a write to a full FIFO.
  assign push     = wr_tx && !full;
  assign pop      = (state == IDLE) && !empty;
  assign bit_done = (bit_cnt == CW'(DELAY_FRAMES - 1));

  always_comb begin
    status                  = '0;
    status[0]               = full;
    status[1]               = empty;
    status[2]               = busy;
    status[3]               = overflow;
    status[4 +: FIFO_AW+1]  = count;
    if (sel_st) rdata = status;
    else        rdata = '0;
  end

  // FIFO bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      if (wr_tx && full)
        overflow <= 1'b1;
      else if (write_enable && sel_st)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            data_out <= '0;
    else if (read_enable) data_out <= rdata;
  end

  // Serializer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      uart_tx <= tx_d;
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    case (state)
      IDLE: begin
        if (!empty) begin
          shift_d   = mem[rd_ptr];
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (bit_idx == 3'd7) state_d   = STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is computed from the next state so the output flop
    // presents it in the same cycle the FSM enters that state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: self-checking bench for uart_tx_mmio (DELAY_FRAMES=4).
// A queue-based model tracks FIFO contents, the sticky overflow flag and
// the position within the frame on the line; every cycle the line level
// and data_out are compared against it.
module tb_uart_tx_mmio;

  localparam int D     = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  q[$];
  logic [7:0]  cur;
  bit          ovf;
  int          frame_left;   // cycles remaining in the frame being sent
  logic [31:0] dout_m;

  uart_tx_mmio #(
    .ADDR_WIDTH  (8),
    .DELAY_FRAMES(D),
    .FIFO_AW     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .uart_tx     (uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (q.size() == DEPTH);
    s[1]   = (q.size() == 0);
    s[2]   = (frame_left > 0);
    s[3]   = ovf;
    s[7:4] = 4'(q.size());
    return s;
  endfunction

  // Line level from frame position: start bit, 8 data bits LSB first, stop bit.
  function automatic logic m_tx();
    int pos, b;
    if (frame_left == 0) return 1'b1;
    pos = 10*D - frame_left;
    b   = pos / D;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic m_reset();
    q.delete();
    ovf        = 1'b0;
    frame_left = 0;
    dout_m     = '0;
  endtask

  // Called at a falling edge: drives one bus cycle, advances the model
  // across the next rising edge, then compares.
  task automatic tick(input bit we, input bit re, input logic [7:0] a, input logic [31:0] d);
    int n;
    bit was_full;
    write_enable = we;
    read_enable  = re;
    address      = a;
    data_in      = d;
    n        = q.size();
    was_full = (n == DEPTH);
    if (re) dout_m = (a == 8'd1) ? m_status() : 32'h0;
    if (frame_left == 0 && n > 0) begin
      cur        = q.pop_front();
      frame_left = 10*D;
    end else if (frame_left > 0) begin
      frame_left--;
    end
    if (we && a == 8'd0) begin
      if (was_full) ovf = 1'b1;
      else          q.push_back(d[7:0]);
    end else if (we && a == 8'd1) begin
      ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    check("tx", {31'b0, uart_tx}, {31'b0, m_tx()});
    check("dout", data_out, dout_m);
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0, 32'h0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset(input int hold);
    #2 reset = 1'b1;
    #1;
    check("rst_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_dout", data_out, 32'h0);
    m_reset();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_tick();
    int r;
    logic [7:0] a;
    r = $urandom_range(0, 7);
    if (r <= 4)      a = 8'd0;
    else if (r == 5) a = 8'd1;
    else if (r == 6) a = 8'd2;
    else             a = 8'hFF;
    tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0), a, $urandom);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check("init_tx", {31'b0, uart_tx}, 32'h1);
    check("init_dout", data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    tick(1'b0, 1'b1, 8'd1, 32'h0);
    check("st_after_rst", data_out, 32'h2);

    // single byte
    tick(1'b1, 1'b0, 8'd0, 32'h55);
    tick(1'b0, 1'b1, 8'd1, 32'h0);
    check("single_low", {31'b0, uart_tx}, 32'h0);
    idle(45);

    // back-to-back frames
    tick(1'b1, 1'b0, 8'd0, 32'hA3);
    tick(1'b1, 1'b0, 8'd0, 32'h0F);
    tick(1'b0, 1'b1, 8'd1, 32'h0);
    check("b2b_count", {28'b0, data_out[7:4]}, 32'h1);
    idle(100);

    // overflow
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'd0, 32'(i));
    tick(1'b0, 1'b1, 8'd1, 32'h0);
    check("ovf_status", data_out, 32'h8D);
    tick(1'b1, 1'b0, 8'd1, 32'h0);
    tick(1'b0, 1'b1, 8'd1, 32'h0);
    check("ovf_clear", {31'b0, data_out[3]}, 32'h0);

    // write on the pop edge while full
    for (int k = 0; k < 200 && frame_left != 0; k++) idle(1);
    check("fp_full_before", {31'b0, m_status()[0]}, 32'h1);
    tick(1'b1, 1'b0, 8'd0, 32'hEE);
    tick(1'b0, 1'b1, 8'd1, 32'h0);
    check("fp_count", {28'b0, data_out[7:4]}, 32'h7);
    check("fp_ovf", {31'b0, data_out[3]}, 32'h1);
    idle(8*(10*D+1) + 20);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0)
        for (int j = 0; j < 10; j++) tick(1'b1, 1'b0, 8'd0, $urandom);
      else
        rand_tick();
    end
    idle(9*(10*D+1) + 10);

    // reset during the data bits of a frame
    tick(1'b1, 1'b0, 8'd0, 32'hC6);
    idle(20);
    tick(1'b0, 1'b1, 8'd1, 32'h0);
    do_reset(2);
    idle(60);
    tick(1'b0, 1'b1, 8'd1, 32'h0);
    check("rst2_status", data_out, 32'h2);
    tick(1'b1, 1'b0, 8'd0, 32'h3C);
    idle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
